// File: rtl/btn_defs.sv
// Package: btn_defs
// Shared definitions for the button debouncer slice.
//  btn_state_t : per-channel press classifier states.
//                S_UP   - debounced level released
//                S_DOWN - pressed, hold counter running
//                S_HELD - pressed past the long-press threshold, hold counter frozen
//                The unused encoding 2'b11 is treated as illegal and recovers to S_UP.
package btn_defs;

   typedef enum logic [1:0] {
      S_UP   = 2'b00,
      S_DOWN = 2'b01,
      S_HELD = 2'b10
   } btn_state_t;

endpackage

// File: rtl/debounce_chan.sv
// Module: debounce_chan
// One button channel: 2-flop synchronizer, debounce counter, press classifier FSM,
// hold counter and sticky pending flag.
// Ports:
//  i_clk      in   1  system clock
//  i_reset_n  in   1  asynchronous, active-low reset
//  i_btn      in   1  raw pin, already polarity-normalized (1 = pressed), asynchronous
//  i_ack      in   1  clears o_pending
//  o_btn      out  1  debounced level, 1 = pressed
//  o_press    out  1  1-cycle strobe on accepted press
//  o_release  out  1  1-cycle strobe on accepted release
//  o_long     out  1  1-cycle strobe when the hold reaches LONGPRESS cycles
//  o_pending  out  1  sticky, set by o_press, cleared by i_ack
module debounce_chan
   import btn_defs::*;
#(
   parameter int DEBOUNCE  = 50000,
   parameter int LONGPRESS = 25000000
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_btn,
   input  logic i_ack,
   output logic o_btn,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_pending
);

   localparam int DB_W   = $clog2(DEBOUNCE);
   localparam int HOLD_W = $clog2(LONGPRESS);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS - 1);

   logic              sync_meta;
   logic              sync_q;
   logic [DB_W-1:0]   db_cnt;
   logic              btn_q;
   logic [HOLD_W-1:0] hold_cnt;
   btn_state_t        state;
   btn_state_t        state_nxt;
   logic              accept;
   logic              accept_press;
   logic              accept_release;
   logic              press_nxt;
   logic              release_nxt;
   logic              long_nxt;

   // Synchronizer resets to 0, i.e. the normalized "released" level, so a pin
   // held pressed through reset is seen as a fresh edge afterwards.
   // NOTE: sequential state always uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours (the two sync stages rely on it).
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
      end else begin
         sync_meta <= i_btn;
         sync_q    <= sync_meta;
      end
   end

   // A new level is accepted on the edge where the counter has already seen
   // DEBOUNCE-1 differing cycles and the synced level still differs.
   assign accept         = (sync_q != btn_q) && (db_cnt == DB_LAST);
   assign accept_press   = accept & ~btn_q;
   assign accept_release = accept &  btn_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         db_cnt <= '0;
         btn_q  <= 1'b0;
      end else begin
         // Agreement or acceptance restarts the count; it therefore never wraps.
         if ((sync_q == btn_q) || accept) db_cnt <= '0;
         else                             db_cnt <= db_cnt + DB_W'(1);
         if (accept) btn_q <= ~btn_q;
      end
   end

   assign o_btn = btn_q;

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= S_UP;
      else            state <= state_nxt;
   end

   // Next-state logic; release beats a coincident long-press threshold.
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = S_UP;
      case (state)
         S_UP:    state_nxt = accept_press ? S_DOWN : S_UP;
         S_DOWN: begin
            if (accept_release)              state_nxt = S_UP;
            else if (hold_cnt == HOLD_LAST)  state_nxt = S_HELD;
            else                             state_nxt = S_DOWN;
         end
         S_HELD:  state_nxt = accept_release ? S_UP : S_HELD;
         default: state_nxt = S_UP;
      endcase
   end

   // Output logic: next values of the registered strobes
   always_comb begin
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      long_nxt    = 1'b0;
      case (state)
         S_UP:    press_nxt   = accept_press;
         S_DOWN: begin
            release_nxt = accept_release;
            long_nxt    = ~accept_release && (hold_cnt == HOLD_LAST);
         end
         S_HELD:  release_nxt = accept_release;
         default: ;
      endcase
   end

   // Strobes, hold counter and pending flag
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_long    <= 1'b0;
         o_pending <= 1'b0;
         hold_cnt  <= '0;
      end else begin
         o_press   <= press_nxt;
         o_release <= release_nxt;
         o_long    <= long_nxt;
         // Set wins over a same-cycle acknowledge.
         o_pending <= o_press | (o_pending & ~i_ack);
         case (state)
            S_DOWN:  if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HOLD_W'(1);
            S_HELD:  hold_cnt <= hold_cnt;
            default: hold_cnt <= '0;
         endcase
      end
   end

endmodule

// File: rtl/button_debouncer.sv
// Module: button_debouncer
// Conditions NBTN raw push-button pins into debounced levels, press/release/long
// strobes and sticky pending flags. Channels are fully independent.
// Ports:
//  i_clk      in   1     system clock
//  i_reset_n  in   1     asynchronous, active-low reset
//  i_btn      in   NBTN  raw, asynchronous button pins
//  i_ack      in   NBTN  per-channel clear of o_pending
//  o_btn      out  NBTN  debounced level, 1 = pressed
//  o_press    out  NBTN  1-cycle strobe on accepted press
//  o_release  out  NBTN  1-cycle strobe on accepted release
//  o_long     out  NBTN  1-cycle strobe when press duration reaches LONGPRESS
//  o_pending  out  NBTN  sticky, set by o_press, cleared by i_ack
module button_debouncer #(
   parameter int NBTN       = 2,
   parameter int DEBOUNCE   = 50000,
   parameter int LONGPRESS  = 25000000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic [NBTN-1:0] i_btn,
   input  logic [NBTN-1:0] i_ack,
   output logic [NBTN-1:0] o_btn,
   output logic [NBTN-1:0] o_press,
   output logic [NBTN-1:0] o_release,
   output logic [NBTN-1:0] o_long,
   output logic [NBTN-1:0] o_pending
);

   // Normalize to 1 = pressed; an XOR per pin is glitch-equivalent to doing it
   // after the synchronizer, and lets each channel reset its flops to 0.
   logic [NBTN-1:0] btn_norm;
   assign btn_norm = i_btn ^ {NBTN{ACTIVE_LOW}};

   for (genvar g = 0; g < NBTN; g++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE  (DEBOUNCE),
         .LONGPRESS (LONGPRESS)
      ) u_chan (
         .i_clk     (i_clk),
         .i_reset_n (i_reset_n),
         .i_btn     (btn_norm[g]),
         .i_ack     (i_ack[g]),
         .o_btn     (o_btn[g]),
         .o_press   (o_press[g]),
         .o_release (o_release[g]),
         .o_long    (o_long[g]),
         .o_pending (o_pending[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with NBTN=2, DEBOUNCE=4, LONGPRESS=10,
// ACTIVE_LOW=1. Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_button_debouncer;

   localparam int NBTN = 2;

   logic            i_clk = 1'b0;
   logic            i_reset_n;
   logic [NBTN-1:0] i_btn;
   logic [NBTN-1:0] i_ack;
   logic [NBTN-1:0] o_btn;
   logic [NBTN-1:0] o_press;
   logic [NBTN-1:0] o_release;
   logic [NBTN-1:0] o_long;
   logic [NBTN-1:0] o_pending;

   int checks_total  = 0;
   int checks_passed = 0;

   button_debouncer #(
      .NBTN       (NBTN),
      .DEBOUNCE   (4),
      .LONGPRESS  (10),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_btn     (i_btn),
      .i_ack     (i_ack),
      .o_btn     (o_btn),
      .o_press   (o_press),
      .o_release (o_release),
      .o_long    (o_long),
      .o_pending (o_pending)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [NBTN-1:0] obs, input logic [NBTN-1:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Advance n rising edges, landing 1 ns after the last one.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " o_btn"},     o_btn,     2'b00);
      check({tag, " o_press"},   o_press,   2'b00);
      check({tag, " o_release"}, o_release, 2'b00);
      check({tag, " o_long"},    o_long,    2'b00);
      check({tag, " o_pending"}, o_pending, 2'b00);
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_btn     = 2'b11;
      i_ack     = 2'b00;
      cyc(2);
      check_all_zero("reset");
      i_reset_n = 1'b1;
      cyc(3);
      check_all_zero("idle");

      // 1. Glitch of 3 cycles on pin0 must never reach the outputs.
      i_btn[0] = 1'b0;
      cyc(3);
      i_btn[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         check("glitch o_btn",     o_btn,     2'b00);
         check("glitch o_press",   o_press,   2'b00);
         check("glitch o_pending", o_pending, 2'b00);
      end

      // 2. Clean press: o_btn/o_press exactly 6 cycles after the edge.
      i_btn[0] = 1'b0;
      cyc(5);
      check("press-1 o_btn",   o_btn,   2'b00);
      check("press-1 o_press", o_press, 2'b00);
      cyc(1);
      check("press o_btn",     o_btn,     2'b01);
      check("press o_press",   o_press,   2'b01);
      check("press o_pending", o_pending, 2'b00);
      cyc(1);
      check("press+1 o_press",   o_press,   2'b00);
      check("press+1 o_pending", o_pending, 2'b01);

      // 3. Long press 10 cycles after o_press, single pulse.
      cyc(8);
      check("long-1 o_long", o_long, 2'b00);
      cyc(1);
      check("long o_long", o_long, 2'b01);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         check("held o_long", o_long, 2'b00);
      end

      // 4. Release after long press: 6 cycles after the edge.
      i_btn[0] = 1'b1;
      cyc(5);
      check("rel-1 o_btn",     o_btn,     2'b01);
      check("rel-1 o_release", o_release, 2'b00);
      cyc(1);
      check("rel o_btn",     o_btn,     2'b00);
      check("rel o_release", o_release, 2'b01);
      cyc(1);
      check("rel+1 o_release", o_release, 2'b00);
      check("rel+1 o_pending", o_pending, 2'b01);

      // Clear the flag left by the first press.
      i_ack = 2'b01;
      cyc(1);
      i_ack = 2'b00;
      check("ack clears", o_pending, 2'b00);

      // 5. New press with i_ack in the o_press cycle: set wins.
      i_btn[0] = 1'b0;
      cyc(6);
      check("press2 o_press", o_press, 2'b01);
      i_ack = 2'b01;
      cyc(1);
      i_ack = 2'b00;
      check("ack+press o_pending", o_pending, 2'b01);
      i_ack = 2'b01;
      cyc(1);
      i_ack = 2'b00;
      check("ack alone o_pending", o_pending, 2'b00);

      // 4b. Release lands on hold-count 9: release wins, no o_long.
      cyc(2);
      i_btn[0] = 1'b1;
      cyc(5);
      check("rel9-1 o_long",    o_long,    2'b00);
      check("rel9-1 o_release", o_release, 2'b00);
      check("rel9-1 o_btn",     o_btn,     2'b01);
      cyc(1);
      check("rel9 o_release", o_release, 2'b01);
      check("rel9 o_long",    o_long,    2'b00);
      check("rel9 o_btn",     o_btn,     2'b00);
      cyc(1);
      check("rel9+1 o_long",    o_long,    2'b00);
      check("rel9+1 o_release", o_release, 2'b00);
      cyc(3);

      // 6. Both pins together, async reset mid-S_DOWN, re-press after reset.
      i_btn = 2'b00;
      cyc(6);
      check("dual o_press", o_press, 2'b11);
      check("dual o_btn",   o_btn,   2'b11);
      cyc(2);
      check("dual o_pending", o_pending, 2'b11);
      #2;
      i_reset_n = 1'b0;
      #1;
      check_all_zero("async reset");
      cyc(2);
      check_all_zero("in reset");
      i_reset_n = 1'b1;
      cyc(5);
      check("post-reset-1 o_press", o_press, 2'b00);
      check("post-reset-1 o_btn",   o_btn,   2'b00);
      cyc(1);
      check("post-reset o_press", o_press, 2'b11);
      check("post-reset o_btn",   o_btn,   2'b11);
      cyc(1);
      check("post-reset+1 o_press",   o_press,   2'b00);
      check("post-reset+1 o_pending", o_pending, 2'b11);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
